// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the RAMProc write and read paths.
// Contents: address/pixel widths, IMAGE_STATE encodings, per-zoom frame
// sizes, the full framebuffer size and the frame_writer state encoding.
// frame_size() maps a zoom state to its pixel count.
package fb_pkg;

   localparam int FB_ADDR_W = 17;
   localparam int PIX_W     = 8;

   typedef enum logic [1:0] {
      IMG_NORMAL     = 2'b00,
      IMG_ZOOM_IN    = 2'b01,
      IMG_ZOOM_OUT   = 2'b10,
      IMG_NORMAL_ALT = 2'b11
   } img_state_t;

   localparam logic [FB_ADDR_W-1:0] FRAME_N_NORMAL     = 17'd19200;  // 160x120
   localparam logic [FB_ADDR_W-1:0] FRAME_N_ZOOM_IN    = 17'd76800;  // 320x240
   localparam logic [FB_ADDR_W-1:0] FRAME_N_ZOOM_OUT   = 17'd4800;   // 80x60
   localparam logic [FB_ADDR_W-1:0] FRAME_N_NORMAL_ALT = 17'd19200;
   localparam logic [FB_ADDR_W-1:0] FB_MAX             = 17'd76800;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_FIN
   } fb_state_t;

   function automatic logic [FB_ADDR_W-1:0] frame_size(input logic [1:0] image_state);
      case (img_state_t'(image_state))
         IMG_ZOOM_IN:  return FRAME_N_ZOOM_IN;
         IMG_ZOOM_OUT: return FRAME_N_ZOOM_OUT;
         IMG_NORMAL:   return FRAME_N_NORMAL;
         default:      return FRAME_N_NORMAL_ALT;
      endcase
   endfunction

endpackage

// File: rtl/frame_writer.sv
// Write-side controller for the RAMProc framebuffer.
// Accepts processed pixels over a valid/ready handshake, optionally zero-fills
// the whole framebuffer first, and drives the RAM write port through one
// register stage with bounds checking against the latched frame size.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   START, IMAGE_STATE    frame start pulse (IDLE only) and zoom state latched with it
//   PIX_VALID/ADDR/DATA   upstream pixel stream
//   PIX_READY             pixel accepted this cycle when PIX_VALID is high
//   RAM_WREN/WRADDR/DATA  RAMProc write port (registered)
//   BUSY                  frame in progress
//   DONE                  one-cycle completion pulse
//   ERR                   sticky: an out-of-range pixel was dropped this frame
//   PIX_COUNT             pixels accepted in the current or last frame
module frame_writer
   import fb_pkg::*;
#(
   parameter int ADDR_W   = FB_ADDR_W,
   parameter int DATA_W   = PIX_W,
   parameter bit CLEAR_EN = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [1:0]        IMAGE_STATE,
   input  logic              PIX_VALID,
   input  logic [ADDR_W-1:0] PIX_ADDR,
   input  logic [DATA_W-1:0] PIX_DATA,
   output logic              PIX_READY,
   output logic              RAM_WREN,
   output logic [ADDR_W-1:0] RAM_WRADDR,
   output logic [DATA_W-1:0] RAM_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [ADDR_W-1:0] PIX_COUNT
);

   localparam logic [ADDR_W-1:0] CLR_END = ADDR_W'(FB_MAX);

   fb_state_t         state, state_nxt;
   logic [ADDR_W-1:0] frame_n;
   logic [ADDR_W-1:0] clr_next;      // next clear address to issue
   logic [ADDR_W-1:0] pix_count;
   logic [ADDR_W-1:0] pix_count_inc;
   logic              err;
   logic              start_ok, accept, last_pix, clr_last, in_range;

   logic              vld_p1;
   logic [ADDR_W-1:0] wraddr_p1;
   logic [DATA_W-1:0] wdata_p1;

   assign start_ok      = (state == ST_IDLE) && START;
   assign accept        = (state == ST_STREAM) && PIX_VALID;
   assign pix_count_inc = pix_count + ADDR_W'(1);
   assign last_pix      = accept && (pix_count_inc == frame_n);
   assign in_range      = PIX_ADDR < frame_n;
   // Address 0 is issued from IDLE on START, so CLEAR ends once all
   // remaining addresses have been issued; the cycle showing the final
   // clear write is therefore the last CLEAR cycle.
   assign clr_last      = (clr_next == CLR_END);

   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      PIX_READY = 1'b0;
      BUSY      = 1'b1;
      DONE      = 1'b0;
      case (state)
         ST_IDLE: begin
            BUSY = 1'b0;
            if (START) state_nxt = CLEAR_EN ? ST_CLEAR : ST_STREAM;
         end
         ST_CLEAR: begin
            if (clr_last) state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            PIX_READY = 1'b1;
            if (last_pix) state_nxt = ST_FIN;
         end
         ST_FIN: begin
            DONE      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         frame_n   <= '0;
         clr_next  <= '0;
         pix_count <= '0;
         err       <= 1'b0;
      end else begin
         if (start_ok) begin
            frame_n   <= ADDR_W'(frame_size(IMAGE_STATE));
            clr_next  <= ADDR_W'(1);
            pix_count <= '0;
            err       <= 1'b0;
         end else if ((state == ST_CLEAR) && !clr_last) begin
            clr_next <= clr_next + ADDR_W'(1);
         end
         if (accept) begin
            pix_count <= pix_count_inc;
            if (!in_range) err <= 1'b1;
         end
      end
   end

   // Stage p1: registered RAM write port
   always_ff @(posedge CLK) begin
      if (RESET) begin
         vld_p1    <= 1'b0;
         wraddr_p1 <= '0;
         wdata_p1  <= '0;
      end else begin
         vld_p1 <= 1'b0;
         if (start_ok && CLEAR_EN) begin
            vld_p1    <= 1'b1;
            wraddr_p1 <= '0;
            wdata_p1  <= '0;
         end else if ((state == ST_CLEAR) && !clr_last) begin
            vld_p1    <= 1'b1;
            wraddr_p1 <= clr_next;
            wdata_p1  <= '0;
         end else if (accept && in_range) begin
            vld_p1    <= 1'b1;
            wraddr_p1 <= PIX_ADDR;
            wdata_p1  <= PIX_DATA;
         end
      end
   end

   assign RAM_WREN   = vld_p1;
   assign RAM_WRADDR = wraddr_p1;
   assign RAM_DATA   = wdata_p1;
   assign ERR        = err;
   assign PIX_COUNT  = pix_count;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: two instances share the clock, one without
// pre-clear (several randomized frames, reset and START-abuse cases) and
// one with pre-clear (full clear followed by a small frame).
module tb_frame_writer;
   import fb_pkg::*;

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // instance A: CLEAR_EN = 0
   logic        a_rst = 1'b1, a_start = 1'b0, a_valid = 1'b0;
   logic [1:0]  a_img = 2'b00;
   logic [16:0] a_addr = '0;
   logic [7:0]  a_data = '0;
   logic        a_ready, a_wren, a_busy, a_done, a_err;
   logic [16:0] a_wraddr, a_cnt;
   logic [7:0]  a_wdata;

   // instance B: CLEAR_EN = 1
   logic        b_rst = 1'b1, b_start = 1'b0, b_valid = 1'b0;
   logic [1:0]  b_img = 2'b00;
   logic [16:0] b_addr = '0;
   logic [7:0]  b_data = '0;
   logic        b_ready, b_wren, b_busy, b_done, b_err;
   logic [16:0] b_wraddr, b_cnt;
   logic [7:0]  b_wdata;

   frame_writer #(.ADDR_W(17), .DATA_W(8), .CLEAR_EN(1'b0)) dut_a (
      .CLK(clk), .RESET(a_rst), .START(a_start), .IMAGE_STATE(a_img),
      .PIX_VALID(a_valid), .PIX_ADDR(a_addr), .PIX_DATA(a_data),
      .PIX_READY(a_ready), .RAM_WREN(a_wren), .RAM_WRADDR(a_wraddr),
      .RAM_DATA(a_wdata), .BUSY(a_busy), .DONE(a_done), .ERR(a_err),
      .PIX_COUNT(a_cnt));

   frame_writer #(.ADDR_W(17), .DATA_W(8), .CLEAR_EN(1'b1)) dut_b (
      .CLK(clk), .RESET(b_rst), .START(b_start), .IMAGE_STATE(b_img),
      .PIX_VALID(b_valid), .PIX_ADDR(b_addr), .PIX_DATA(b_data),
      .PIX_READY(b_ready), .RAM_WREN(b_wren), .RAM_WRADDR(b_wraddr),
      .RAM_DATA(b_wdata), .BUSY(b_busy), .DONE(b_done), .ERR(b_err),
      .PIX_COUNT(b_cnt));

   // write / done monitors
   wr_t wq_a[$];
   wr_t wq_b[$];
   int  a_done_cnt = 0, a_done_cyc = -1, b_done_cnt = 0;

   always @(negedge clk) begin
      if (a_wren) wq_a.push_back(wr_t'{a_wraddr, a_wdata, cyc});
      if (b_wren) wq_b.push_back(wr_t'{b_wraddr, b_wdata, cyc});
      if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
      if (b_done) b_done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int ref_size(input logic [1:0] img);
      case (img)
         2'b01:   return 76800;
         2'b10:   return 4800;
         default: return 19200;
      endcase
   endfunction

   task automatic cmp_writes(input string tag, input wr_t got[$], input wr_t exp[$]);
      int b0;
      chk({tag, "_nwr"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         b0 = bad;
         chk({tag, "_addr"}, 32'(got[i].addr), 32'(exp[i].addr));
         chk({tag, "_data"}, 32'(got[i].data), 32'(exp[i].data));
         chk({tag, "_cyc"}, got[i].cyc, exp[i].cyc);
         if (bad != b0) break;
      end
   endtask

   task automatic zero_a(input string tag);
      chk({tag, "_rdy"},  a_ready, 0);
      chk({tag, "_wren"}, a_wren, 0);
      chk({tag, "_wadr"}, a_wraddr, 0);
      chk({tag, "_wdat"}, a_wdata, 0);
      chk({tag, "_busy"}, a_busy, 0);
      chk({tag, "_done"}, a_done, 0);
      chk({tag, "_err"},  a_err, 0);
      chk({tag, "_cnt"},  a_cnt, 0);
   endtask

   // One frame on instance A. gap_pct: chance of an idle valid cycle;
   // bad_at/bad_addr: pixel index given an explicit address; spulse_at:
   // pixel index at which a stray START (with a different zoom) is pulsed.
   task automatic frame_a(input logic [1:0] img, input int gap_pct, input int bad_at,
                          input logic [16:0] bad_addr, input int spulse_at);
      wr_t exp_q[$];
      int  n, acc, s, first_acc, last_acc, lim, spent, pulse_cyc;
      bit  pend, exp_err, pulsed;
      n = ref_size(img);
      exp_q.delete();
      wq_a.delete();
      a_done_cnt = 0;
      acc = 0; first_acc = -1; last_acc = 0; spent = 0; pulse_cyc = -10;
      pend = 0; exp_err = 0; pulsed = 0;
      lim = n * 3 + 200;
      @(posedge clk); #1;
      a_img = img; a_start = 1'b1; a_valid = 1'b0; s = cyc;
      @(negedge clk);
      chk("idle_rdy", a_ready, 0);
      @(posedge clk); #1;
      a_start = 1'b0;
      while (acc < n && spent < lim) begin
         if (!pend && $urandom_range(0, 99) >= gap_pct) begin
            pend   = 1;
            a_addr = (acc == bad_at) ? bad_addr : 17'(acc);
            a_data = (gap_pct == 0) ? 8'(acc) : 8'($urandom);
         end
         a_valid = pend;
         if (spulse_at >= 0 && !pulsed && acc >= spulse_at) begin
            a_start = 1'b1; a_img = 2'b10; pulsed = 1; pulse_cyc = cyc;
         end
         @(negedge clk);
         if (cyc == s + 1) begin
            chk("err_clr", a_err, 0);
            chk("cnt_clr", a_cnt, 0);
         end
         if (cyc == pulse_cyc + 1) begin
            chk("stray_start_cnt", a_cnt, acc);
            chk("stray_start_rdy", a_ready, 1);
            chk("stray_start_err", a_err, exp_err);
         end
         if (a_valid && a_ready) begin
            if (int'(a_addr) < n) exp_q.push_back(wr_t'{a_addr, a_data, cyc + 1});
            else exp_err = 1;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            acc++;
            pend = 0;
         end
         @(posedge clk); #1;
         a_start = 1'b0; a_img = img; spent++;
      end
      a_valid = 1'b0;
      chk("frame_acc", acc, n);
      if (gap_pct == 0) begin
         chk("first_acc", first_acc, s + 1);
         chk("no_bubble", last_acc, s + n);
      end
      @(negedge clk);
      chk("fin_done", a_done, 1);
      chk("fin_rdy", a_ready, 0);
      chk("fin_busy", a_busy, 1);
      @(negedge clk);
      chk("idle_busy", a_busy, 0);
      chk("idle_done", a_done, 0);
      repeat (3) @(negedge clk);
      chk("done_cnt", a_done_cnt, 1);
      chk("done_cyc", a_done_cyc, last_acc + 1);
      chk("pix_count", a_cnt, n);
      chk("err", a_err, exp_err);
      cmp_writes("wr", wq_a, exp_q);
   endtask

   // Reset asserted in the same cycle as an acceptance mid-frame.
   task automatic reset_mid_a();
      @(posedge clk); #1;
      a_img = 2'b10; a_start = 1'b1; a_valid = 1'b1; a_addr = '0; a_data = 8'h11;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(negedge clk);
      chk("rs_err_clr", a_err, 0);
      chk("rs_cnt_clr", a_cnt, 0);
      chk("rs_rdy", a_ready, 1);
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk); #1;
         a_addr = 17'(k); a_data = 8'(k + 1);
      end
      a_rst = 1'b1;
      @(negedge clk);
      chk("rs_acc_cycle", a_ready, 1);
      chk("rs_cnt_before", a_cnt, 50);
      @(posedge clk); #1;
      a_rst = 1'b0; a_valid = 1'b0;
      @(negedge clk);
      zero_a("rs_after");
      @(negedge clk);
      chk("rs_wren2", a_wren, 0);
      chk("rs_busy2", a_busy, 0);
   endtask

   task automatic run_b();
      wr_t exp_q[$];
      int  s, acc, first_acc, last_acc, lim, spent;
      wq_b.delete();
      b_done_cnt = 0;
      @(posedge clk); #1;
      b_img = 2'b10; b_start = 1'b1; b_valid = 1'b1;
      b_addr = 17'($urandom_range(0, 4799)); b_data = 8'($urandom); s = cyc;
      for (int k = 0; k < 76800; k++) exp_q.push_back(wr_t'{17'(k), 8'h00, s + 1 + k});
      @(posedge clk); #1;
      b_start = 1'b0;
      acc = 0; first_acc = -1; last_acc = 0; spent = 0;
      lim = 76800 + 4800 * 2 + 100;
      while (acc < 4800 && spent < lim) begin
         @(negedge clk);
         if (cyc == s + 76800) begin
            chk("clr_last_rdy", b_ready, 0);
            chk("clr_last_busy", b_busy, 1);
         end
         if (b_valid && b_ready) begin
            exp_q.push_back(wr_t'{b_addr, b_data, cyc + 1});
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            acc++;
            @(posedge clk); #1;
            b_addr = 17'($urandom_range(0, 4799)); b_data = 8'($urandom);
         end else begin
            @(posedge clk); #1;
         end
         spent++;
      end
      b_valid = 1'b0;
      chk("b_acc", acc, 4800);
      chk("b_first_acc", first_acc, s + 76801);
      chk("b_no_bubble", last_acc, s + 76800 + 4800);
      @(negedge clk);
      chk("b_fin_done", b_done, 1);
      repeat (3) @(negedge clk);
      chk("b_done_cnt", b_done_cnt, 1);
      chk("b_pix_count", b_cnt, 4800);
      chk("b_err", b_err, 0);
      chk("b_busy", b_busy, 0);
      cmp_writes("bwr", wq_b, exp_q);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      zero_a("reset");
      chk("b_reset_wren", b_wren, 0);
      chk("b_reset_busy", b_busy, 0);
      chk("b_reset_rdy", b_ready, 0);
      @(posedge clk); #1;
      a_rst = 1'b0; b_rst = 1'b0;
      fork
         begin
            frame_a(2'b10, 0, -1, 17'd0, -1);
            frame_a(2'b00, 30, -1, 17'd0, 5000);
            frame_a(2'b10, 20, 10, 17'd4800, -1);
            repeat (5) @(negedge clk);
            chk("err_hold", a_err, 1);
            chk("cnt_hold", a_cnt, 4800);
            reset_mid_a();
            frame_a(2'b11, 20, -1, 17'd0, -1);
         end
         run_b();
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
